// File: rtl/counter_datapath_p_pkg.sv
// rtl/counter_datapath_p_pkg.sv - shared encodings for the counter datapath
package counter_datapath_p_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic OP_UP     = 1'b0;
  localparam logic OP_DN     = 1'b1;

endpackage

// File: rtl/counter_datapath_p_if.sv
// rtl/counter_datapath_p_if.sv - control/status bundle between the FSM and the counter datapath
interface counter_datapath_p_if #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
);

  logic              op;
  logic              en;
  logic              c_ld;
  logic              c_clr;
  logic              mode;
  logic              lim_ld;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  d_in;
  logic [WIDTH-1:0]  lim_in;
  logic [WIDTH-1:0]  c_out;
  logic [WIDTH-1:0]  limit;
  logic              z;
  logic              m;
  logic              ovf;
  logic              ovf_sticky;

  modport master (
    output op, en, c_ld, c_clr, mode, lim_ld, step, d_in, lim_in,
    input  c_out, limit, z, m, ovf, ovf_sticky
  );

  modport slave (
    input  op, en, c_ld, c_clr, mode, lim_ld, step, d_in, lim_in,
    output c_out, limit, z, m, ovf, ovf_sticky
  );

endinterface

// File: rtl/counter_datapath_p_addsub_nbit.sv
// rtl/counter_datapath_p_addsub_nbit.sv - combinational N-bit add/subtract with carry/borrow out
module addsub_nbit #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] y,
  output logic         co
);

  logic [N:0] full;

  // co is the carry for an add and the borrow for a subtract
  always_comb begin
    if (sub) full = {1'b0, a} - {1'b0, b};
    else     full = {1'b0, a} + {1'b0, b};
  end

  assign y  = full[N-1:0];
  assign co = full[N];

endmodule

// File: rtl/counter_datapath_p.sv
// rtl/counter_datapath_p.sv - up/down counter with programmable step, limit, wrap/saturate and overflow flags
module counter_datapath_p
  import counter_datapath_p_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               STEP_W    = 4,
  parameter logic [WIDTH-1:0] LIMIT_RST = {WIDTH{1'b1}}
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_datapath_p_if.slave  bus
);

  localparam int N = WIDTH + 1;

  logic [WIDTH-1:0]  cnt_q;
  logic [WIDTH-1:0]  lim_q;
  logic              ovf_q;
  logic              sticky_q;

  logic [STEP_W-1:0] step_v;
  logic [WIDTH-1:0]  lim_eff;
  logic [N-1:0]      cnt_x;
  logic [N-1:0]      lim_x;
  logic [N-1:0]      lim_p1;
  logic [N-1:0]      step_x;
  logic [N-1:0]      raw;
  logic              raw_co;
  logic [N-1:0]      corr;
  logic              corr_co;
  logic              is_dn;
  logic              is_sat;
  logic [WIDTH-1:0]  ld_val;
  logic [WIDTH-1:0]  step_nxt;
  logic              step_ovf;

  // A same-cycle limit load is already the bound for c_ld and en
  assign lim_eff = bus.lim_ld ? bus.lim_in : lim_q;
  assign step_v  = bus.step;
  assign cnt_x   = {1'b0, cnt_q};
  assign lim_x   = {1'b0, lim_eff};
  assign lim_p1  = lim_x + N'(1);
  assign step_x  = N'(step_v);
  assign is_dn   = (bus.op == OP_DN);
  assign is_sat  = (bus.mode == MODE_SAT);

  addsub_nbit #(.N(N)) u_raw (
    .a   (cnt_x),
    .b   (step_x),
    .sub (is_dn),
    .y   (raw),
    .co  (raw_co)
  );

  // Wrap correction: up subtracts L+1 from the sum, down adds L+1 to the negative difference
  addsub_nbit #(.N(N)) u_corr (
    .a   (raw),
    .b   (lim_p1),
    .sub (~is_dn),
    .y   (corr),
    .co  (corr_co)
  );

  assign ld_val = (bus.d_in > lim_eff) ? lim_eff : bus.d_in;

  always_comb begin
    step_nxt = cnt_q;
    step_ovf = 1'b0;
    if (step_v == '0) begin
      step_nxt = cnt_q;
    end else if (!is_dn) begin
      if (raw <= lim_x) begin
        step_nxt = raw[WIDTH-1:0];
      end else begin
        step_ovf = 1'b1;
        if (is_sat || (corr > lim_x)) step_nxt = lim_eff;
        else                          step_nxt = corr[WIDTH-1:0];
      end
    end else begin
      if (!raw_co) begin
        step_nxt = raw[WIDTH-1:0];
      end else begin
        step_ovf = 1'b1;
        // No carry out of the correction means the wrapped value is still negative
        if (is_sat || !corr_co) step_nxt = '0;
        else                    step_nxt = corr[WIDTH-1:0];
      end
    end
    if (step_nxt > lim_eff) step_nxt = lim_eff;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      lim_q    <= LIMIT_RST;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (bus.lim_ld) lim_q <= bus.lim_in;
      if (bus.c_clr) begin
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
        sticky_q <= 1'b0;
      end else if (bus.c_ld) begin
        cnt_q <= ld_val;
        ovf_q <= 1'b0;
      end else if (bus.en) begin
        cnt_q <= step_nxt;
        ovf_q <= step_ovf;
        if (step_ovf) sticky_q <= 1'b1;
      end else begin
        ovf_q <= 1'b0;
        if (bus.lim_ld && (cnt_q > bus.lim_in)) cnt_q <= bus.lim_in;
      end
    end
  end

  assign bus.c_out      = cnt_q;
  assign bus.limit      = lim_q;
  assign bus.ovf        = ovf_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.z          = (cnt_q == '0);
  assign bus.m          = (cnt_q == lim_q);

endmodule

// File: tb/tb_counter_datapath_p.sv
// tb/tb_counter_datapath_p.sv - scoreboard bench for counter_datapath_p
module tb_counter_datapath_p;
  import counter_datapath_p_pkg::*;

  typedef struct {
    logic [15:0] c;
    logic [15:0] lim;
    logic        ovf;
    logic        st;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  longint mc, ml, mst;

  always #5 clk = ~clk;

  counter_datapath_p_if #(.WIDTH(16), .STEP_W(4)) bus ();

  counter_datapath_p #(.WIDTH(16), .STEP_W(4), .LIMIT_RST(16'hFFFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic clr, input logic ld, input logic en,
                     input logic op, input logic md, input logic lld, input logic [3:0] stp,
                     input logic [15:0] d, input logic [15:0] li,
                     input logic [15:0] ec, input logic [15:0] el, input logic eo, input logic es);
    exp_t e;
    @(negedge clk);
    reset = r; bus.c_clr = clr; bus.c_ld = ld; bus.en = en; bus.op = op;
    bus.mode = md; bus.lim_ld = lld; bus.step = stp; bus.d_in = d; bus.lim_in = li;
    e.c = ec; e.lim = el; e.ovf = eo; e.st = es;
    q.push_back(e);
  endtask

  // Reference model: plain integer arithmetic on the described behaviour
  task automatic rnd_cyc(input logic r, input logic clr, input logic ld, input logic en,
                         input logic op, input logic md, input logic lld, input logic [3:0] stp,
                         input logic [15:0] d, input logic [15:0] li);
    longint ln, s, w, ov;
    ov = 0;
    if (r) begin
      mc = 0; ml = 16'hFFFF; mst = 0;
    end else begin
      ln = lld ? longint'(li) : ml;
      if (clr) begin
        mc = 0; mst = 0;
      end else if (ld) begin
        mc = (longint'(d) > ln) ? ln : longint'(d);
      end else if (en) begin
        if (stp == 0) begin
          mc = mc;
        end else if (op == OP_UP) begin
          s = mc + longint'(stp);
          if (s <= ln) mc = s;
          else begin
            ov = 1;
            w = s - (ln + 1);
            mc = (md == MODE_SAT || w > ln) ? ln : w;
          end
        end else begin
          if (longint'(stp) <= mc) mc = mc - longint'(stp);
          else begin
            ov = 1;
            w = mc + ln + 1 - longint'(stp);
            mc = (md == MODE_SAT || w < 0) ? 0 : w;
          end
        end
        if (mc > ln) mc = ln;
      end else if (lld && mc > ln) begin
        mc = ln;
      end
      ml = ln;
      if (ov != 0) mst = 1;
    end
    cyc(r, clr, ld, en, op, md, lld, stp, d, li, 16'(mc), 16'(ml), ov[0], mst[0]);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("c_out", bus.c_out, e.c);
        chk("limit", bus.limit, e.lim);
        chk("ovf", bus.ovf, e.ovf);
        chk("ovf_sticky", bus.ovf_sticky, e.st);
        chk("z", bus.z, e.c == 16'h0);
        chk("m", bus.m, e.c == e.lim);
      end
    end
  end

  initial begin : stimulus
    int wait_cyc;
    logic lld, clr, ld, r;
    logic [15:0] li, d;
    reset = 1'b1;
    bus.c_clr = 0; bus.c_ld = 0; bus.en = 0; bus.op = 0; bus.mode = 0;
    bus.lim_ld = 0; bus.step = 0; bus.d_in = 0; bus.lim_in = 0;
    //   r clr ld en op md lld step d       li       c        lim      ovf st
    cyc(1, 0, 0, 0, 0, 0, 0, 4'd0, 16'd0,  16'd0,   16'd0,   16'hFFFF, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 4'd0, 16'd0,  16'd9,   16'd0,   16'd9, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 4'd3, 16'd0,  16'd0,   16'd3,   16'd9, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 4'd3, 16'd0,  16'd0,   16'd6,   16'd9, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 4'd3, 16'd0,  16'd0,   16'd9,   16'd9, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 4'd3, 16'd0,  16'd0,   16'd2,   16'd9, 1, 1);
    cyc(0, 0, 1, 0, 0, 1, 0, 4'd0, 16'd2,  16'd0,   16'd2,   16'd9, 0, 1);
    cyc(0, 0, 0, 1, 1, 1, 0, 4'd5, 16'd0,  16'd0,   16'd0,   16'd9, 1, 1);
    cyc(0, 0, 0, 1, 1, 1, 0, 4'd5, 16'd0,  16'd0,   16'd0,   16'd9, 1, 1);
    cyc(0, 0, 1, 0, 0, 1, 0, 4'd0, 16'd20, 16'd0,   16'd9,   16'd9, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 1, 4'd0, 16'd0,  16'd5,   16'd5,   16'd5, 0, 1);
    cyc(0, 0, 0, 1, 0, 1, 0, 4'd3, 16'd0,  16'd0,   16'd5,   16'd5, 1, 1);
    cyc(0, 0, 0, 1, 0, 1, 0, 4'd0, 16'd0,  16'd0,   16'd5,   16'd5, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 0, 4'd0, 16'd1,  16'd0,   16'd1,   16'd5, 0, 1);
    cyc(0, 0, 0, 1, 1, 0, 0, 4'd3, 16'd0,  16'd0,   16'd4,   16'd5, 1, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 4'd15, 16'd0, 16'd0,   16'd5,   16'd5, 1, 1);
    cyc(0, 0, 0, 1, 1, 0, 0, 4'd15, 16'd0, 16'd0,   16'd0,   16'd5, 1, 1);
    cyc(0, 1, 1, 1, 0, 0, 0, 4'd3, 16'd4,  16'd0,   16'd0,   16'd5, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 4'd2, 16'd0,  16'd0,   16'd2,   16'd5, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 1, 4'd2, 16'd0,  16'd7,   16'd0,   16'hFFFF, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 4'd0, 16'hFFFE, 16'd0, 16'hFFFE, 16'hFFFF, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 4'd3, 16'd0,  16'd0,   16'd1,   16'hFFFF, 1, 1);
    cyc(0, 0, 0, 1, 0, 0, 1, 4'd4, 16'd0,  16'd10,  16'd5,   16'd10, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 4'd0, 16'd0,  16'd0,   16'd0,   16'd0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 4'd1, 16'd0,  16'd0,   16'd0,   16'd0, 1, 1);
    cyc(0, 0, 0, 1, 1, 0, 0, 4'd2, 16'd0,  16'd0,   16'd0,   16'd0, 1, 1);

    mc = 0; ml = 0; mst = 1;
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 39) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      lld = ($urandom_range(0, 14) == 0) || (i == 0);
      case ($urandom_range(0, 2))
        0:       li = 16'hFFFF;
        1:       li = 16'($urandom_range(0, 40));
        default: li = 16'($urandom);
      endcase
      d = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 60)) : 16'($urandom);
      rnd_cyc(r, clr, ld, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), lld,
              4'($urandom), d, li);
    end

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
